uart_tx: RTL

UART transmitter, the transmit-side counterpart of the LPC-UART receive path. Fixed 115200 baud 8-N-1 from the 33 MHz LPC clock. Accepts bytes through a valid/ready handshake, buffers them, and serialises them LSB-first on `tx`. It sits between the LPC register front-end (THR writes) and the UART pin.

---
 rtl/uart_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with valid/ready byte input and registered serial output.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx #(
    parameter int DIVISOR    = 286,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);
    localparam logic [8:0] LAST = 9'(DIVISOR - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7, S_STOP
    } state_t;

    state_t     state;
    logic [8:0] cnt;
    logic [7:0] shift;
    logic [7:0] head;
    logic       empty, full, push, pop;

    assign push  = data_valid && ready;
    assign ready = !full;
    assign busy  = (state != S_IDLE) || !empty;

    // Pops only look at registered buffer state, so a byte never bypasses the buffer.
    assign pop = !empty && ((state == S_IDLE) || (state == S_STOP && cnt == LAST));

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= data;
    end
`else
    logic [7:0] hold;
    logic       hold_full;

    assign empty = !hold_full;
    assign full  = hold_full;
    assign head  = hold;

    // push and pop are mutually exclusive here: push needs empty, pop needs full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (push) begin
            hold      <= data;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    tx  <= 1'b1;
                    if (pop) begin
                        shift <= head;
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                default: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 9'd1;
                    end else begin
                        cnt <= '0;
                        if (state == S_STOP) begin
                            if (pop) begin
                                shift <= head;
                                state <= S_START;
                                tx    <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                tx    <= 1'b1;
                            end
                        end else if (state == S_D7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            // START..D6: the next data state sends bit (state - S_START).
                            state <= state_t'(state + 4'd1);
                            tx    <= shift[3'(state - S_START)];
                        end
                    end
                end
            endcase
        end
    end
endmodule
